// File: rtl/cache_write_buffer_pkg.sv
// rtl/cache_write_buffer_pkg.sv - shared constants for the write-through store buffer
package cache_write_buffer_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;

  // Byte-address split at the default width: block | word_loc
  localparam int BLK_HI  = DEF_ADDR_W - 1;
  localparam int BLK_LO  = 2;
  localparam int WLOC_HI = 1;
  localparam int WLOC_LO = 0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

endpackage

// File: rtl/cache_write_buffer_if.sv
// rtl/cache_write_buffer_if.sv - controller/memory side bundle of the store buffer
interface cache_write_buffer_if
  import cache_write_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                     st_req;
  logic [ADDR_W-1:0]        st_A;
  logic [DATA_W-1:0]        st_data;
  logic                     buf_full;
  logic                     buf_empty;
  logic                     rd_req;
  logic [ADDR_W-BLK_LO-1:0] rd_A;
  logic                     rd_grant;
  logic                     mem_WE;
  logic [ADDR_W-BLK_LO-1:0] mem_A;
  logic [1:0]               mem_word_loc;
  logic [DATA_W-1:0]        mem_WD;
  logic                     mem_done;

  modport master (
    output st_req, st_A, st_data, rd_req, rd_A, mem_done,
    input  buf_full, buf_empty, rd_grant, mem_WE, mem_A, mem_word_loc, mem_WD
  );

  modport slave (
    input  st_req, st_A, st_data, rd_req, rd_A, mem_done,
    output buf_full, buf_empty, rd_grant, mem_WE, mem_A, mem_word_loc, mem_WD
  );

endinterface

// File: rtl/cache_write_buffer_wb_fifo.sv
// rtl/cache_write_buffer_wb_fifo.sv - store FIFO with per-entry valid bits and block-address hazard match
module wb_fifo
  import cache_write_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic [ADDR_W-BLK_LO-1:0] match_blk,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic                     hazard
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      // wr_ptr==rd_ptr only when empty or full, so push and pop never hit the same slot
      if (push_ok) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][ADDR_W-1:BLK_LO] == match_blk)) hazard = 1'b1;
    end
  end

endmodule

// File: rtl/cache_write_buffer.sv
// rtl/cache_write_buffer.sv - write-through store buffer arbitrating memory between store drain and line fills
module cache_write_buffer
  import cache_write_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic                 clk,
  input logic                 RST,
  cache_write_buffer_if.slave bus
);

  // Package split is laid out for the default width; shift the block MSB for other widths
  localparam int BLK_TOP = BLK_HI + (ADDR_W - DEF_ADDR_W);

  logic [1:0]        state;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              full;
  logic              empty;
  logic              hazard;
  logic              pop;

  assign pop = (state == WRITE) && bus.mem_done;

  wb_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (RST),
    .push      (bus.st_req),
    .push_addr (bus.st_A),
    .push_data (bus.st_data),
    .pop       (pop),
    .match_blk (bus.rd_A),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .hazard    (hazard)
  );

  assign bus.buf_full  = full;
  assign bus.buf_empty = empty;
  assign bus.rd_grant  = (state == READ);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      bus.mem_WE       <= 1'b0;
      bus.mem_A        <= '0;
      bus.mem_word_loc <= '0;
      bus.mem_WD       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A fill wins over draining unless it would read a block still owed a store
          if (bus.rd_req && !hazard) begin
            state <= READ;
          end else if (!empty) begin
            state            <= WRITE;
            bus.mem_WE       <= 1'b1;
            bus.mem_A        <= head_addr[BLK_TOP:BLK_LO];
            bus.mem_word_loc <= head_addr[WLOC_HI:WLOC_LO];
            bus.mem_WD       <= head_data;
          end
        end
        WRITE: begin
          if (bus.mem_done) begin
            state      <= IDLE;
            bus.mem_WE <= 1'b0;
          end
        end
        READ: begin
          if (bus.mem_done || !bus.rd_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
